// File: rtl/recfg_cla_pipe.sv
// Two-stage pipelined segmented adder with per-segment exact/approximate carry selection.
// Optional error detection (err, err_cnt) is built when RECFG_CLA_ERRDET_EN is defined.
module recfg_cla_pipe #(
  parameter int SEG_W = 4,
  parameter int NSEG  = 4,
  localparam int W    = SEG_W * NSEG
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [W-1:0]    a,
  input  logic [W-1:0]    b,
  input  logic            cin,
  input  logic            cfg_we,
  input  logic [NSEG-1:0] cfg_mode,
  output logic [NSEG-1:0] mode,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [W-1:0]    sum,
  output logic            cout
`ifdef RECFG_CLA_ERRDET_EN
  ,
  output logic            err,
  output logic [15:0]     err_cnt
`endif
);

  logic            s1_valid_reg;
  logic [W-1:0]    s1_a_reg;
  logic [W-1:0]    s1_b_reg;
  logic            s1_cin_reg;
  logic [NSEG-1:1] s1_mode_reg;
  logic            pend_reg;
  logic [NSEG-1:0] pend_mode_reg;

  logic            s2_free;
  logic            s1_adv;
  logic            accept;
  logic            pipe_empty;
  logic [W-1:0]    sum_next;
  logic            cout_next;
  logic [NSEG-1:1] approx_c;

  assign s2_free    = !out_valid || out_ready;
  assign s1_adv     = s1_valid_reg && s2_free;
  assign pipe_empty = !s1_valid_reg && !out_valid;
  // A pending config freezes intake so the mode switch lands on an empty pipe.
  assign in_ready   = rst_n && !pend_reg && (!s1_valid_reg || s1_adv);
  assign accept     = in_valid && in_ready;

  // Speculative carry: generate term of the top bit of the segment below.
  generate
    for (genvar gi = 1; gi < NSEG; gi++) begin : g_approx
      assign approx_c[gi] = s1_a_reg[gi*SEG_W-1] & s1_b_reg[gi*SEG_W-1];
    end
  endgenerate

  always_comb begin
    logic [SEG_W:0] seg;
    logic           carry;
    sum_next = '0;
    seg = {1'b0, s1_a_reg[SEG_W-1:0]} + {1'b0, s1_b_reg[SEG_W-1:0]}
        + {{SEG_W{1'b0}}, s1_cin_reg};
    sum_next[SEG_W-1:0] = seg[SEG_W-1:0];
    carry = seg[SEG_W];
    for (int i = 1; i < NSEG; i++) begin
      if (!s1_mode_reg[i]) begin
        carry = approx_c[i];
      end
      seg = {1'b0, s1_a_reg[i*SEG_W +: SEG_W]} + {1'b0, s1_b_reg[i*SEG_W +: SEG_W]}
          + {{SEG_W{1'b0}}, carry};
      sum_next[i*SEG_W +: SEG_W] = seg[SEG_W-1:0];
      carry = seg[SEG_W];
    end
    cout_next = carry;
  end

`ifdef RECFG_CLA_ERRDET_EN
  logic [W:0] exact_next;
  logic       err_next;
  assign exact_next = {1'b0, s1_a_reg} + {1'b0, s1_b_reg} + {{W{1'b0}}, s1_cin_reg};
  assign err_next   = (exact_next != {cout_next, sum_next});

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err     <= 1'b0;
      err_cnt <= '0;
    end else begin
      if (out_valid && out_ready && err && (err_cnt != 16'hFFFF)) begin
        err_cnt <= err_cnt + 16'd1;
      end
      if (s1_adv) begin
        err <= err_next;
      end
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_reg  <= 1'b0;
      s1_a_reg      <= '0;
      s1_b_reg      <= '0;
      s1_cin_reg    <= 1'b0;
      s1_mode_reg   <= '1;
      out_valid     <= 1'b0;
      sum           <= '0;
      cout          <= 1'b0;
      pend_reg      <= 1'b0;
      pend_mode_reg <= '1;
      mode          <= '1;
    end else begin
      if (accept) begin
        s1_valid_reg <= 1'b1;
        s1_a_reg     <= a;
        s1_b_reg     <= b;
        s1_cin_reg   <= cin;
        s1_mode_reg  <= mode[NSEG-1:1];
      end else if (s1_adv) begin
        s1_valid_reg <= 1'b0;
      end

      if (s2_free) begin
        out_valid <= s1_valid_reg;
      end
      if (s1_adv) begin
        sum  <= sum_next;
        cout <= cout_next;
      end

      // A fresh write always wins over applying the previously pending value.
      if (cfg_we) begin
        pend_reg      <= 1'b1;
        pend_mode_reg <= cfg_mode;
      end else if (pend_reg && pipe_empty) begin
        mode     <= pend_mode_reg;
        pend_reg <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_recfg_cla_pipe.sv
// Scoreboard bench for recfg_cla_pipe: random beats/configs checked against a segment-level adder model.
module tb_recfg_cla_pipe;
  localparam int SEG_W = 4;
  localparam int NSEG  = 4;
  localparam int W     = SEG_W * NSEG;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [W-1:0]    a;
  logic [W-1:0]    b;
  logic            cin;
  logic            cfg_we;
  logic [NSEG-1:0] cfg_mode;
  logic [NSEG-1:0] mode;
  logic            out_valid;
  logic            out_ready;
  logic [W-1:0]    sum;
  logic            cout;
`ifdef RECFG_CLA_ERRDET_EN
  logic            err;
  logic [15:0]     err_cnt;
`endif

  recfg_cla_pipe #(.SEG_W(SEG_W), .NSEG(NSEG)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .cfg_we(cfg_we), .cfg_mode(cfg_mode), .mode(mode),
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout)
`ifdef RECFG_CLA_ERRDET_EN
    , .err(err), .err_cnt(err_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] s;
    logic         co;
    logic         e;
  } exp_t;

  exp_t            q[$];
  int              total = 0;
  int              bad   = 0;
  int              nbeat = 0;
  int              err_model = 0;
  logic [NSEG-1:0] mode_model = '1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Reference: per-segment addition where each upper segment takes either the
  // real carry from below or the AND of the two operand bits just below it.
  function automatic logic [W:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic c, input logic [NSEG-1:0] m);
    int unsigned carry, xs, ys, s, mask;
    logic [W-1:0] r;
    carry = c;
    r = '0;
    mask = (1 << SEG_W) - 1;
    for (int i = 0; i < NSEG; i++) begin
      xs = (x >> (i*SEG_W)) & mask;
      ys = (y >> (i*SEG_W)) & mask;
      if (i > 0 && !m[i]) carry = ((x >> (i*SEG_W-1)) & (y >> (i*SEG_W-1)) & 1);
      s = xs + ys + carry;
      r = r | (W'(s & mask) << (i*SEG_W));
      carry = s >> SEG_W;
    end
    return {carry[0], r};
  endfunction

  // Monitor: pop and compare each transferred result.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_out actual=sum %h required=no beat", sum);
      end else begin
        exp_t e;
        e = q.pop_front();
        nbeat++;
        $display("beat %0d: sum=%h cout=%b expect sum=%h cout=%b", nbeat, sum, cout, e.s, e.co);
        chk("sum", 32'(sum), 32'(e.s));
        chk("cout", 32'(cout), 32'(e.co));
`ifdef RECFG_CLA_ERRDET_EN
        chk("err", 32'(err), 32'(e.e));
        if (e.e && err_model < 16'hFFFF) err_model++;
`endif
      end
    end
  end

  task automatic cycle(input logic v, input logic [W-1:0] av, input logic [W-1:0] bv,
                       input logic c, input logic orr, output logic acc);
    logic [W:0] r;
    exp_t e;
    in_valid = v; a = av; b = bv; cin = c; out_ready = orr; cfg_we = 1'b0;
    @(negedge clk);
    acc = v && (in_ready === 1'b1);
    if (acc) begin
      r = ref_add(av, bv, c, mode_model);
      e.s = r[W-1:0];
      e.co = r[W];
      e.e = (r != ({1'b0, av} + {1'b0, bv} + (W+1)'(c)));
      q.push_back(e);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // rdy: 0 = hold low, 1 = high, 2 = random
  task automatic send(input logic [W-1:0] av, input logic [W-1:0] bv, input logic c, input int rdy);
    logic acc;
    logic orr;
    int   n = 0;
    acc = 1'b0;
    while (!acc && n < 60) begin
      orr = (rdy == 1) || (rdy == 2 && $urandom_range(0, 3) != 0);
      cycle(1'b1, av, bv, c, orr, acc);
      n++;
    end
    if (!acc) begin
      total++;
      bad++;
      $display("FAIL accept_timeout actual=not accepted required=accepted");
    end
  endtask

  task automatic idle(input logic orr);
    logic acc;
    cycle(1'b0, '0, '0, 1'b0, orr, acc);
  endtask

  task automatic cfg(input logic [NSEG-1:0] m, input logic orr);
    in_valid = 1'b0; cfg_we = 1'b1; cfg_mode = m; out_ready = orr;
    @(posedge clk);
    #1;
    cfg_we = 1'b0;
    mode_model = m;
  endtask

  task automatic drain();
    int n = 0;
    while ((q.size() != 0 || out_valid === 1'b1) && n < 50) begin
      idle(1'b1);
      n++;
    end
    chk("drain_empty", 32'(q.size()), 32'd0);
  endtask

  initial begin
    logic [W-1:0] sa[8];
    logic [W-1:0] sb[8];
    logic acc;
    int   k;
    int   cyc;
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0;
    cfg_we = 1'b0; cfg_mode = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_mode", 32'(mode), 32'hF);
    chk("rst_sum", 32'({cout, sum}), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);

    // Exact carry, two-cycle latency.
    send(16'h00FF, 16'h0001, 1'b0, 1);
    chk("lat_cycle1_valid", 32'(out_valid), 32'd0);
    idle(1'b1);
    chk("lat_cycle2_valid", 32'(out_valid), 32'd1);
    send(16'hFFFF, 16'h0001, 1'b0, 1);
    drain();

    // Fully approximate upper segments.
    cfg(4'b0001, 1'b1);
    idle(1'b1);
    chk("mode_applied", 32'(mode), 32'h1);
    send(16'h00FF, 16'h0001, 1'b0, 1);
    drain();
    cfg(4'hF, 1'b1);
    idle(1'b1);

    // 8-beat stream with output stall on cycles 3..5.
    for (int i = 0; i < 8; i++) begin
      sa[i] = W'($urandom());
      sb[i] = W'($urandom());
    end
    k = 0;
    cyc = 0;
    while (k < 8 && cyc < 100) begin
      cycle(1'b1, sa[k], sb[k], k[0], !(cyc >= 3 && cyc <= 5), acc);
      if (acc) k++;
      cyc++;
    end
    chk("stream_count", 32'(k), 32'd8);
    drain();

    // Config with two beats in flight; second write overwrites the first.
    send(16'h0F0F, 16'h0101, 1'b0, 0);
    send(16'h00FF, 16'h0001, 1'b0, 0);
    cfg(4'b0101, 1'b0);
    cfg(4'b0011, 1'b0);
    chk("cfg_blocks_ready", 32'(in_ready), 32'd0);
    chk("cfg_mode_held", 32'(mode), 32'hF);
    send(16'h0FFF, 16'h0001, 1'b0, 1);
    chk("cfg_mode_new", 32'(mode), 32'h3);
    drain();

    // Randomized traffic with occasional reconfiguration.
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 7) == 0) cfg(NSEG'($urandom()), 1'($urandom()));
      else send(W'($urandom()), W'($urandom()), 1'($urandom()), 2);
    end
    drain();
`ifdef RECFG_CLA_ERRDET_EN
    chk("err_cnt", 32'(err_cnt), 32'(err_model));
`endif

    // Reset with pipeline full and a config pending.
    send(16'h1234, 16'h4321, 1'b0, 0);
    send(16'h5555, 16'hAAAA, 1'b1, 0);
    cfg(4'b0110, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_mid_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    chk("rst_mid_out_valid", 32'(out_valid), 32'd0);
    chk("rst_mid_mode", 32'(mode), 32'hF);
    q.delete();
    mode_model = '1;
    err_model = 0;
    rst_n = 1'b1;
    repeat (6) idle(1'b1);
    chk("rst_mid_ready_after", 32'(in_ready), 32'd1);
    chk("rst_mid_mode_after", 32'(mode), 32'hF);
    send(16'h0008, 16'h0008, 1'b1, 1);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
